// File: rtl/prim_rom_arb_ctrl.sv
// Round-robin two-port front end for a one-cycle-latency ROM, with an optional
// post-reset XOR checksum sweep that holds off all requesters until it is done.
module prim_rom_arb_ctrl #(
  parameter int               Width       = 32,
  parameter int               Depth       = 2048,
  parameter bit               CheckEn     = 1'b1,
  parameter logic [Width-1:0] ExpChecksum = '0,
  localparam int              Aw          = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_req_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic             b_req_i,
  input  logic [Aw-1:0]    b_addr_i,
  output logic             a_gnt_o,
  output logic             b_gnt_o,
  output logic             a_rvalid_o,
  output logic             b_rvalid_o,
  output logic [Width-1:0] a_rdata_o,
  output logic [Width-1:0] b_rdata_o,
  output logic             rom_req_o,
  output logic [Aw-1:0]    rom_addr_o,
  input  logic [Width-1:0] rom_rdata_i,
  output logic             check_done_o,
  output logic             check_ok_o
);

  typedef enum logic [1:0] {
    StInit,
    StSweep,
    StFinal,
    StRun
  } state_e;

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  state_e           state_q;
  logic [Aw-1:0]    cnt_q;
  logic [Width-1:0] acc_q;
  logic             sweep_vld_q;
  logic             prio_q;       // 0 favours A, 1 favours B
  logic             rvld_q;
  logic             rsel_q;       // 0 = A, 1 = B
  logic             check_done_q;
  logic             check_ok_q;
  logic             a_gnt;
  logic             b_gnt;

  // Grants depend only on the current requests and state, never on the ROM.
  always_comb begin
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    rom_req_o  = 1'b0;
    rom_addr_o = '0;
    unique case (state_q)
      StSweep: begin
        rom_req_o  = 1'b1;
        rom_addr_o = cnt_q;
      end
      StRun: begin
        a_gnt = a_req_i && (!b_req_i || !prio_q);
        b_gnt = b_req_i && (!a_req_i ||  prio_q);
        if (a_gnt) begin
          rom_req_o  = 1'b1;
          rom_addr_o = a_addr_i;
        end else if (b_gnt) begin
          rom_req_o  = 1'b1;
          rom_addr_o = b_addr_i;
        end
      end
      StInit, StFinal: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StInit;
      cnt_q        <= '0;
      acc_q        <= '0;
      sweep_vld_q  <= 1'b0;
      prio_q       <= 1'b0;
      rvld_q       <= 1'b0;
      rsel_q       <= 1'b0;
      check_done_q <= 1'b0;
      check_ok_q   <= 1'b0;
    end else begin
      sweep_vld_q <= (state_q == StSweep);
      if (sweep_vld_q) begin
        acc_q <= acc_q ^ rom_rdata_i;
      end

      rvld_q <= a_gnt || b_gnt;
      if (a_gnt) begin
        rsel_q <= 1'b0;
        prio_q <= 1'b1;
      end else if (b_gnt) begin
        rsel_q <= 1'b1;
        prio_q <= 1'b0;
      end

      unique case (state_q)
        StInit: begin
          if (CheckEn) begin
            state_q <= StSweep;
          end else begin
            state_q      <= StRun;
            check_done_q <= 1'b1;
            check_ok_q   <= 1'b1;
          end
        end
        StSweep: begin
          if (cnt_q == LastAddr) begin
            state_q <= StFinal;
          end else begin
            cnt_q <= cnt_q + Aw'(1);
          end
        end
        // The last swept word arrives here, so it is folded into the compare directly.
        StFinal: begin
          check_done_q <= 1'b1;
          check_ok_q   <= ((acc_q ^ rom_rdata_i) == ExpChecksum);
          state_q      <= StRun;
        end
        StRun: begin
        end
        default: begin
          state_q <= StInit;
        end
      endcase
    end
  end

  assign a_gnt_o      = a_gnt;
  assign b_gnt_o      = b_gnt;
  assign a_rvalid_o   = rvld_q && !rsel_q;
  assign b_rvalid_o   = rvld_q &&  rsel_q;
  assign a_rdata_o    = rom_rdata_i;
  assign b_rdata_o    = rom_rdata_i;
  assign check_done_o = check_done_q;
  assign check_ok_o   = check_ok_q;

endmodule

// File: tb/tb_prim_rom_arb_ctrl.sv
// Directed bench: three Depth=5 controllers (sweep pass, sweep fail, no sweep)
// sharing stimulus, each backed by a ROM model holding 0x100+address.
module tb_prim_rom_arb_ctrl;

  logic        clk;
  logic        rst;
  logic        a_req;
  logic        b_req;
  logic [2:0]  a_addr;
  logic [2:0]  b_addr;
  logic [2:0]  a_gnt, b_gnt, a_rvalid, b_rvalid, rom_req, check_done, check_ok;
  logic [2:0]  rom_addr  [3];
  logic [31:0] a_rdata   [3];
  logic [31:0] b_rdata   [3];
  int          passed;
  int          total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: checksum passes, 1: checksum fails, 2: sweep disabled.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] rom_q;
    always @(posedge clk) begin
      if (rom_req[g]) rom_q <= 32'h100 + {29'd0, rom_addr[g]};
    end
    prim_rom_arb_ctrl #(
      .Width(32), .Depth(5), .CheckEn(g != 2),
      .ExpChecksum((g == 1) ? 32'h105 : 32'h104)
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .a_req_i(a_req), .a_addr_i(a_addr), .b_req_i(b_req), .b_addr_i(b_addr),
      .a_gnt_o(a_gnt[g]), .b_gnt_o(b_gnt[g]),
      .a_rvalid_o(a_rvalid[g]), .b_rvalid_o(b_rvalid[g]),
      .a_rdata_o(a_rdata[g]), .b_rdata_o(b_rdata[g]),
      .rom_req_o(rom_req[g]), .rom_addr_o(rom_addr[g]), .rom_rdata_i(rom_q),
      .check_done_o(check_done[g]), .check_ok_o(check_ok[g])
    );
  end

  // Leaves the bench in the cycle-0 window (before the first edge after release).
  task automatic release_reset();
    rst = 1'b1;
    a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
    repeat (2) @(negedge clk);
    a_req = 1'b1; b_req = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      total++; if (a_gnt[g] !== 1'b0 || b_gnt[g] !== 1'b0) $display("[TB] FAIL reset_gnt[%0d]: got %b%b expected 00", g, a_gnt[g], b_gnt[g]); else passed++;
      total++; if (a_rvalid[g] !== 1'b0 || b_rvalid[g] !== 1'b0) $display("[TB] FAIL reset_rvalid[%0d]: got %b%b expected 00", g, a_rvalid[g], b_rvalid[g]); else passed++;
      total++; if (rom_req[g] !== 1'b0 || rom_addr[g] !== 3'd0) $display("[TB] FAIL reset_rom[%0d]: got req %b addr %0d expected 0/0", g, rom_req[g], rom_addr[g]); else passed++;
      total++; if (check_done[g] !== 1'b0 || check_ok[g] !== 1'b0) $display("[TB] FAIL reset_check[%0d]: got %b%b expected 00", g, check_done[g], check_ok[g]); else passed++;
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_sweep();
    release_reset();
    a_req = 1'b1; a_addr = 3'd3;
    #1;
    total++; if (rom_req[0] !== 1'b0 || a_gnt[0] !== 1'b0) $display("[TB] FAIL sweep_c0: got req %b gnt %b expected 0/0", rom_req[0], a_gnt[0]); else passed++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      total++; if (rom_req[0] !== 1'b1 || rom_addr[0] !== 3'(k - 1)) $display("[TB] FAIL sweep_addr c%0d: got req %b addr %0d expected 1/%0d", k, rom_req[0], rom_addr[0], k - 1); else passed++;
      total++; if (a_gnt[0] !== 1'b0 || a_gnt[1] !== 1'b0) $display("[TB] FAIL sweep_blocked c%0d: got %b%b expected 00", k, a_gnt[0], a_gnt[1]); else passed++;
      total++; if (check_done[0] !== 1'b0) $display("[TB] FAIL sweep_done_early c%0d: got %b expected 0", k, check_done[0]); else passed++;
    end
    @(negedge clk); #1;
    total++; if (rom_req[0] !== 1'b0 || a_gnt[0] !== 1'b0 || check_done[0] !== 1'b0) $display("[TB] FAIL sweep_final c6: got req %b gnt %b done %b expected 000", rom_req[0], a_gnt[0], check_done[0]); else passed++;
    @(negedge clk); #1;
    total++; if (check_done[0] !== 1'b1 || check_ok[0] !== 1'b1) $display("[TB] FAIL sweep_pass c7: got done %b ok %b expected 1/1", check_done[0], check_ok[0]); else passed++;
    total++; if (check_done[1] !== 1'b1 || check_ok[1] !== 1'b0) $display("[TB] FAIL sweep_fail c7: got done %b ok %b expected 1/0", check_done[1], check_ok[1]); else passed++;
    total++; if (a_gnt[0] !== 1'b1 || a_gnt[1] !== 1'b1) $display("[TB] FAIL sweep_first_gnt c7: got %b%b expected 11", a_gnt[0], a_gnt[1]); else passed++;
    total++; if (rom_req[0] !== 1'b1 || rom_addr[0] !== 3'd3) $display("[TB] FAIL sweep_gnt_addr c7: got req %b addr %0d expected 1/3", rom_req[0], rom_addr[0]); else passed++;
    @(negedge clk);
    a_req = 1'b0;
    #1;
    total++; if (a_rvalid[0] !== 1'b1 || a_rdata[0] !== 32'h103) $display("[TB] FAIL sweep_rvalid c8: got %b %h expected 1 00000103", a_rvalid[0], a_rdata[0]); else passed++;
    total++; if (a_rvalid[1] !== 1'b1 || a_rdata[1] !== 32'h103 || b_rvalid[1] !== 1'b0) $display("[TB] FAIL fail_inst_run c8: got a %b %h b %b expected 1 00000103 0", a_rvalid[1], a_rdata[1], b_rvalid[1]); else passed++;
    @(negedge clk); #1;
    total++; if (a_rvalid[0] !== 1'b0 || rom_req[0] !== 1'b0 || rom_addr[0] !== 3'd0) $display("[TB] FAIL sweep_idle c9: got rvalid %b req %b addr %0d expected 0/0/0", a_rvalid[0], rom_req[0], rom_addr[0]); else passed++;
  endtask

  task automatic test_contention();
    bit exp_a;
    release_reset();
    #1;
    total++; if (check_done[2] !== 1'b0) $display("[TB] FAIL nocheck_c0_done: got %b expected 0", check_done[2]); else passed++;
    @(negedge clk);
    a_req = 1'b1; a_addr = 3'd1; b_req = 1'b1; b_addr = 3'd2;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      exp_a = (k % 2) == 1;
      if (k == 1) begin
        total++; if (check_done[2] !== 1'b1 || check_ok[2] !== 1'b1) $display("[TB] FAIL nocheck_c1: got done %b ok %b expected 1/1", check_done[2], check_ok[2]); else passed++;
      end
      total++; if (a_gnt[2] !== exp_a || b_gnt[2] !== !exp_a) $display("[TB] FAIL contention_gnt c%0d: got a%b b%b expected a%b b%b", k, a_gnt[2], b_gnt[2], exp_a, !exp_a); else passed++;
      total++; if (rom_req[2] !== 1'b1 || rom_addr[2] !== (exp_a ? 3'd1 : 3'd2)) $display("[TB] FAIL contention_rom c%0d: got req %b addr %0d", k, rom_req[2], rom_addr[2]); else passed++;
      if (k > 1) begin
        total++; if (a_rvalid[2] !== !exp_a || b_rvalid[2] !== exp_a) $display("[TB] FAIL contention_rvalid c%0d: got a%b b%b expected a%b b%b", k, a_rvalid[2], b_rvalid[2], !exp_a, exp_a); else passed++;
        total++; if ((exp_a ? b_rdata[2] : a_rdata[2]) !== (exp_a ? 32'h102 : 32'h101)) $display("[TB] FAIL contention_rdata c%0d: got %h", k, exp_a ? b_rdata[2] : a_rdata[2]); else passed++;
      end
    end
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    #1;
    total++; if (b_rvalid[2] !== 1'b1 || b_rdata[2] !== 32'h102 || a_rvalid[2] !== 1'b0) $display("[TB] FAIL contention_last: got b %b %h a %b expected 1 00000102 0", b_rvalid[2], b_rdata[2], a_rvalid[2]); else passed++;
    total++; if (a_gnt[2] !== 1'b0 || b_gnt[2] !== 1'b0 || rom_req[2] !== 1'b0) $display("[TB] FAIL contention_release: got a%b b%b req %b expected 000", a_gnt[2], b_gnt[2], rom_req[2]); else passed++;
    @(negedge clk); #1;
    total++; if (a_rvalid[2] !== 1'b0 || b_rvalid[2] !== 1'b0 || rom_addr[2] !== 3'd0) $display("[TB] FAIL contention_idle: got a%b b%b addr %0d expected 0 0 0", a_rvalid[2], b_rvalid[2], rom_addr[2]); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b_req = 1'b1; b_addr = 3'(i);
      #1;
      total++; if (b_gnt[2] !== 1'b1 || rom_addr[2] !== 3'(i) || a_rvalid[2] !== 1'b0) $display("[TB] FAIL stream_gnt %0d: got gnt %b addr %0d a_rvalid %b expected 1/%0d/0", i, b_gnt[2], rom_addr[2], a_rvalid[2], i); else passed++;
      if (i > 0) begin
        total++; if (b_rvalid[2] !== 1'b1 || b_rdata[2] !== 32'h100 + 32'(i - 1)) $display("[TB] FAIL stream_data %0d: got %b %h expected 1 %h", i, b_rvalid[2], b_rdata[2], 32'h100 + 32'(i - 1)); else passed++;
      end
    end
    @(negedge clk);
    b_req = 1'b0;
    #1;
    total++; if (b_rvalid[2] !== 1'b1 || b_rdata[2] !== 32'h104 || a_rvalid[2] !== 1'b0) $display("[TB] FAIL stream_last: got b %b %h a %b expected 1 00000104 0", b_rvalid[2], b_rdata[2], a_rvalid[2]); else passed++;
  endtask

  // After B-only traffic the pointer favours A; B then waits exactly one grant.
  task automatic test_fairness();
    @(negedge clk);
    a_req = 1'b1; a_addr = 3'd4; b_req = 1'b1; b_addr = 3'd0;
    #1;
    total++; if (a_gnt[2] !== 1'b1 || b_gnt[2] !== 1'b0) $display("[TB] FAIL fair_first: got a%b b%b expected a1 b0", a_gnt[2], b_gnt[2]); else passed++;
    @(negedge clk);
    a_req = 1'b0;
    #1;
    total++; if (b_gnt[2] !== 1'b1 || a_rvalid[2] !== 1'b1 || a_rdata[2] !== 32'h104) $display("[TB] FAIL fair_second: got b_gnt %b a_rvalid %b %h expected 1 1 00000104", b_gnt[2], a_rvalid[2], a_rdata[2]); else passed++;
    @(negedge clk);
    b_req = 1'b0;
    #1;
    total++; if (b_rvalid[2] !== 1'b1 || b_rdata[2] !== 32'h100) $display("[TB] FAIL fair_data: got %b %h expected 1 00000100", b_rvalid[2], b_rdata[2]); else passed++;
  endtask

  task automatic test_mid_reset();
    release_reset();
    repeat (3) @(negedge clk);
    #1;
    total++; if (rom_req[0] !== 1'b1 || rom_addr[0] !== 3'd2) $display("[TB] FAIL midrst_pre: got req %b addr %0d expected 1/2", rom_req[0], rom_addr[0]); else passed++;
    rst = 1'b1;
    #1;
    total++; if (rom_req[0] !== 1'b0 || rom_addr[0] !== 3'd0 || check_done[0] !== 1'b0 || a_rvalid[0] !== 1'b0) $display("[TB] FAIL midrst_sweep: got req %b addr %0d done %b rvalid %b expected 0/0/0/0", rom_req[0], rom_addr[0], check_done[0], a_rvalid[0]); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    total++; if (rom_req[0] !== 1'b1 || rom_addr[0] !== 3'd0) $display("[TB] FAIL midrst_restart0: got req %b addr %0d expected 1/0", rom_req[0], rom_addr[0]); else passed++;
    @(negedge clk); #1;
    total++; if (rom_addr[0] !== 3'd1) $display("[TB] FAIL midrst_restart1: got addr %0d expected 1", rom_addr[0]); else passed++;

    release_reset();
    @(negedge clk);
    a_req = 1'b1; a_addr = 3'd2;
    #1;
    total++; if (a_gnt[2] !== 1'b1) $display("[TB] FAIL midrst_run_gnt: got %b expected 1", a_gnt[2]); else passed++;
    @(negedge clk);
    a_req = 1'b0; rst = 1'b1;
    #1;
    total++; if (a_rvalid[2] !== 1'b0 || check_done[2] !== 1'b0 || rom_req[2] !== 1'b0) $display("[TB] FAIL midrst_run: got rvalid %b done %b req %b expected 0/0/0", a_rvalid[2], check_done[2], rom_req[2]); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    total++; if (a_rvalid[2] !== 1'b0 || b_rvalid[2] !== 1'b0) $display("[TB] FAIL midrst_run_after: got a%b b%b expected 00", a_rvalid[2], b_rvalid[2]); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    a_req  = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
    test_reset();
    test_sweep();
    test_contention();
    test_back_to_back();
    test_fairness();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prim_rom_arb_ctrl.md
# prim_rom_arb_ctrl

Controller placed in front of a single-port, one-cycle-latency ROM primitive. It shares the ROM between two requesters A and B using a req/gnt/rvalid handshake with round-robin arbitration. After reset it optionally performs an integrity sweep: it reads every word, XORs them together and compares the result against a parameterised expected checksum. Requesters receive no grants until this sweep has finished.

## Interface
- Width, 32, ROM word width
- Depth, 2048, number of ROM words (need not be a power of two)
- Aw, $clog2(Depth), localparam, address width
- CheckEn, 1'b1, enable the post-reset checksum sweep
- ExpChecksum, '0 (Width bits), expected XOR of all Depth words
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- a_req_i / b_req_i  in  1  read request from requester A / B
- a_addr_i / b_addr_i  in  Aw  word address from requester A / B
- a_gnt_o / b_gnt_o  out  1  request accepted this cycle (combinational)
- a_rvalid_o / b_rvalid_o  out  1  read data valid, one cycle after grant
- a_rdata_o / b_rdata_o  out  Width  read data; meaningful only with rvalid
- rom_req_o  out  1  ROM read strobe
- rom_addr_o  out  Aw  ROM address
- rom_rdata_i  in  Width  ROM data, registered in the ROM, valid the cycle after rom_req_o
- check_done_o  out  1  sweep finished (sticky until reset)
- check_ok_o  out  1  checksum matched; valid when check_done_o=1

## Operation
- FSM states: INIT, SWEEP, FINAL, RUN. Reset state is INIT.
- INIT (one cycle): no ROM request. Next state is SWEEP if CheckEn=1. If CheckEn=0, next state is RUN and check_done_o and check_ok_o are set to 1.
- SWEEP:
  - rom_req_o=1 and rom_addr_o=cnt every cycle; cnt starts at 0 and increments by 1.
  - When cnt==Depth-1 is issued, move to FINAL. The counter never wraps.
- Accumulator: sweep_vld_q is rom_req_o registered during SWEEP. When sweep_vld_q=1, acc <= acc ^ rom_rdata_i.
- FINAL:
  - No ROM request.
  - Folds in the last word.
  - Registers check_done_o=1 and check_ok_o=((acc^rom_rdata_i)==ExpChecksum).
  - Moves to RUN. RUN is terminal until reset.
- RUN arbitration:
  - If only one requester asserts req, it is granted.
  - If both assert req, the one selected by prio_q is granted.
  - After any grant, prio_q points at the other requester. Reset value of prio_q is A.
  - At most one grant per cycle.
- On grant:
  - rom_req_o=1 and rom_addr_o = the granted requester's address.
  - rvld_q<=1 and rsel_q<=granted id.
- Response: the next cycle, <x>_rvalid_o = rvld_q && rsel_q==x. Both rdata outputs are driven from rom_rdata_i.
- Back-to-back grants are permitted, giving one read per cycle sustained.
- Requester contract: req and addr are held stable until gnt is seen.
- Outside RUN, both gnt outputs are 0 and requests wait. In SWEEP/FINAL, held requests are neither dropped nor errored.
- If RUN is idle, rom_req_o=0 and rom_addr_o=0.

## Timing
- Reset values:
  - gnt=0, rvalid=0, rdata=rom_rdata_i passthrough.
  - rom_req_o=0, rom_addr_o=0.
  - check_done_o=0, check_ok_o=0.
  - cnt=0, acc=0, prio_q=A, rvld_q=0.
- Latency: grant to rvalid is exactly 1 cycle.
- Cycle numbering below counts from the first edge after rst_i falls, as cycle 0.
  - CheckEn=1: INIT is cycle 0, SWEEP is cycles 1..Depth, FINAL is cycle Depth+1. check_done_o is high and grants are possible from cycle Depth+2.
  - CheckEn=0: check_done_o=check_ok_o=1 and grants are possible from cycle 1.
- Fairness: a requester holding req waits at most one grant to the other requester.
- Reset mid-operation: all state returns to reset values immediately (asynchronously). An outstanding rvalid is dropped, and the sweep restarts from address 0 after release.
- Grant is a combinational function of req and state only. There is no path from gnt back to req.

## Test plan
- Sweep pass:
  - Setup: Depth=5, CheckEn=1, ROM words 0x100+i, ExpChecksum=0x104.
  - Response: rom_addr_o is 0..4 on cycles 1..5; check_done_o=1 and check_ok_o=1 at cycle 7.
- Sweep fail:
  - Setup: same as sweep pass, but ExpChecksum=0x105.
  - Response: check_done_o=1 and check_ok_o=0 at cycle 7; RUN grants still work.
- Blocked during sweep:
  - Stimulus: a_req_i=1 with addr 3 from cycle 0.
  - Response: a_gnt_o=0 through cycle 6, gnt at cycle 7, a_rvalid_o=1 with data 0x103 at cycle 8.
- Contention:
  - Setup: CheckEn=0.
  - Stimulus: A and B both request continuously from cycle 1, A addr 1, B addr 2.
  - Response: grants alternate A,B,A,B; rvalids alternate with data 0x101/0x102 one cycle later; rom_req_o is high every cycle.
- Single requester streaming: B requests addresses 0..4 back-to-back, giving 5 grants in 5 cycles and 5 consecutive rvalids with correct data; a_rvalid_o stays 0.
- Mid-operation reset:
  - Stimulus: assert rst_i during SWEEP at cnt=2, and separately one cycle after a RUN grant.
  - Response: no rvalid is emitted; check_done_o=0; the sweep restarts at address 0.
